ula_pipe_regbank: RTL and testbench

Parametrised, pipelined successor to the two-bit-opcode ULA with its register bank. Accepts one operation per cycle on a valid/ready input channel, combines the operand `A` with a selected bank register, and returns a double-width result on a valid/ready output channel. It adds the following over the previous generation:
- generic data width and register count;
- an extended opcode set with register-writing ops;
- full backpressure.

It sits between the stimulus master (mst modport side) and the result consumer.

---
 rtl/ula_pkg.sv | 47 ++++
 rtl/ula_regbank.sv | 32 +++
 rtl/ula_pipe_regbank.sv | 97 +++++++++
 tb/tb_ula_pipe_regbank.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// Shared opcode encoding, default sizing and the result function for the
// pipelined ULA.
package ula_pkg;

    localparam int ULA_DATA_W_DEF   = 16;
    localparam int ULA_NUM_REGS_DEF = 4;
    // Widest operand the result function handles; callers zero-extend into it.
    localparam int ULA_MAX_W        = 32;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MUL  = 3'b010,
        OP_AND  = 3'b011,
        OP_OR   = 3'b100,
        OP_XOR  = 3'b101,
        OP_LOAD = 3'b110,
        OP_ACC  = 3'b111
    } ula_op_e;

    // Operands arrive zero-extended, so the full-width difference already
    // equals the sign extension of the narrow one once truncated to 2*DATA_W.
    function automatic logic [2*ULA_MAX_W-1:0] ula_compute(
        input ula_op_e              op,
        input logic [ULA_MAX_W-1:0] a,
        input logic [ULA_MAX_W-1:0] r
    );
        logic [2*ULA_MAX_W-1:0] a_x;
        logic [2*ULA_MAX_W-1:0] r_x;
        logic [2*ULA_MAX_W-1:0] res;
        a_x = {{ULA_MAX_W{1'b0}}, a};
        r_x = {{ULA_MAX_W{1'b0}}, r};
        case (op)
            OP_ADD:  res = a_x + r_x;
            OP_SUB:  res = a_x - r_x;
            OP_MUL:  res = a_x * r_x;
            OP_AND:  res = a_x & r_x;
            OP_OR:   res = a_x | r_x;
            OP_XOR:  res = a_x ^ r_x;
            OP_LOAD: res = a_x;
            OP_ACC:  res = a_x + r_x;
            default: res = '0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/ula_regbank.sv
// Register bank: one combinational read port, one synchronous write port,
// asynchronously cleared.
module ula_regbank #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 4,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [SEL_W-1:0]  rsel,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[wsel] <= wdata;
        end
    end

    // NUM_REGS is a power of two, so every rsel value addresses a register.
    assign rdata = regs[rsel];

endmodule

// File: rtl/ula_pipe_regbank.sv
// Two-stage ULA pipeline (S1 operand capture, S2 output register) with a
// register bank and valid/ready flow control on both sides.
module ula_pipe_regbank
    import ula_pkg::*;
#(
    parameter int DATA_W   = ULA_DATA_W_DEF,
    parameter int NUM_REGS = ULA_NUM_REGS_DEF,
    parameter int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic                clk_ula,
    input  logic                rst,
    input  logic [DATA_W-1:0]   A,
    input  logic [SEL_W-1:0]    reg_sel,
    input  logic [2:0]          instru,
    input  logic                valid_ula,
    output logic                ready_ula,
    output logic [2*DATA_W-1:0] data_out,
    output logic                zero_out,
    output logic                valid_out,
    input  logic                ready_out
);

    logic                s1_valid;
    ula_op_e             s1_op;
    logic [DATA_W-1:0]   s1_a;
    logic [DATA_W-1:0]   s1_r;

    logic                s2_free;
    logic                accept;
    logic                advance;
    ula_op_e             in_op;
    logic [DATA_W-1:0]   rd_data;
    logic                wr_en;
    logic [DATA_W-1:0]   wr_data;
    logic [2*DATA_W-1:0] s1_result;

    assign in_op     = ula_op_e'(instru);
    assign s2_free   = !valid_out || ready_out;
    assign ready_ula = !s1_valid || s2_free;
    assign accept    = valid_ula && ready_ula;
    assign advance   = s1_valid && s2_free;

    // The bank is written on the accept edge, so the next accepted
    // transaction reads the new value without any forwarding path.
    assign wr_en   = accept && (in_op == OP_LOAD || in_op == OP_ACC);
    assign wr_data = (in_op == OP_LOAD) ? A : A + rd_data;

    ula_regbank #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_regbank (
        .clk   (clk_ula),
        .rst   (rst),
        .we    (wr_en),
        .wsel  (reg_sel),
        .wdata (wr_data),
        .rsel  (reg_sel),
        .rdata (rd_data)
    );

    always_ff @(posedge clk_ula or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_ADD;
            s1_a     <= '0;
            s1_r     <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= in_op;
            s1_a     <= A;
            s1_r     <= rd_data;
        end else if (advance) begin
            s1_valid <= 1'b0;
        end
    end

    assign s1_result = (2*DATA_W)'(ula_compute(s1_op,
                                               ULA_MAX_W'(s1_a),
                                               ULA_MAX_W'(s1_r)));

    // S2 only changes on advance; a consume without refill just drops valid.
    always_ff @(posedge clk_ula or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            zero_out  <= 1'b0;
        end else if (advance) begin
            valid_out <= 1'b1;
            data_out  <= s1_result;
            zero_out  <= (s1_result == '0);
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ula_pipe_regbank.sv
// Directed bench for ula_pipe_regbank: reset, bank ops, arithmetic corners,
// backpressure and mid-stream reset, checked against hand-computed values.
module tb_ula_pipe_regbank;
    import ula_pkg::*;

    logic        clk_ula = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] A = '0;
    logic [1:0]  reg_sel = '0;
    logic [2:0]  instru = '0;
    logic        valid_ula = 1'b0;
    logic        ready_ula;
    logic [31:0] data_out;
    logic        zero_out;
    logic        valid_out;
    logic        ready_out = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_ula = ~clk_ula;

    ula_pipe_regbank dut (
        .clk_ula   (clk_ula),
        .rst       (rst),
        .A         (A),
        .reg_sel   (reg_sel),
        .instru    (instru),
        .valid_ula (valid_ula),
        .ready_ula (ready_ula),
        .data_out  (data_out),
        .zero_out  (zero_out),
        .valid_out (valid_out),
        .ready_out (ready_out)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_ula);
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [15:0] a, input logic [1:0] sel);
        instru    = op;
        A         = a;
        reg_sel   = sel;
        valid_ula = 1'b1;
    endtask

    // One isolated transaction with ready_out high: result checked at accept+2.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [15:0] a,
                          input logic [1:0] sel, input logic [31:0] exp);
        drive(op, a, sel);
        check({tag, "_rdy"}, 64'(ready_ula), 64'd1);
        step();
        valid_ula = 1'b0;
        step();
        $display("[TB] %s op=%0d A=0x%h sel=%0d -> data=0x%h zero=%0b", tag, op, a, sel,
                 data_out, zero_out);
        check({tag, "_vld"}, 64'(valid_out), 64'd1);
        check({tag, "_data"}, 64'(data_out), 64'(exp));
        check({tag, "_zero"}, 64'(zero_out), (exp == 32'd0) ? 64'd1 : 64'd0);
    endtask

    initial begin
        step();
        step();
        check("rst_valid_out", 64'(valid_out), 64'd0);
        check("rst_data_out", 64'(data_out), 64'd0);
        check("rst_ready_ula", 64'(ready_ula), 64'd1);
        rst = 1'b0;
        step();

        // LOAD then ADD, back-to-back
        drive(OP_LOAD, 16'h1234, 2'd2);
        step();
        drive(OP_ADD, 16'h0001, 2'd2);
        check("b2b_not_early", 64'(valid_out), 64'd0);
        step();
        valid_ula = 1'b0;
        $display("[TB] b2b load -> data=0x%h valid=%0b", data_out, valid_out);
        check("b2b_load_vld", 64'(valid_out), 64'd1);
        check("b2b_load_data", 64'(data_out), 64'h0000_1234);
        step();
        $display("[TB] b2b add -> data=0x%h valid=%0b", data_out, valid_out);
        check("b2b_add_vld", 64'(valid_out), 64'd1);
        check("b2b_add_data", 64'(data_out), 64'h0000_1235);
        step();
        check("b2b_drain", 64'(valid_out), 64'd0);

        // Arithmetic extremes and bitwise ops
        run_op("load_r1", OP_LOAD, 16'hFFFF, 2'd1, 32'h0000_FFFF);
        run_op("mul_max", OP_MUL,  16'hFFFF, 2'd1, 32'hFFFE_0001);
        run_op("load_r3", OP_LOAD, 16'h0002, 2'd3, 32'h0000_0002);
        run_op("sub_neg", OP_SUB,  16'h0001, 2'd3, 32'hFFFF_FFFF);
        run_op("xor_zero", OP_XOR, 16'hFFFF, 2'd1, 32'h0000_0000);
        run_op("add_carry", OP_ADD, 16'hFFFF, 2'd1, 32'h0001_FFFE);
        run_op("and_r2", OP_AND,   16'hFF0F, 2'd2, 32'h0000_1204);
        run_op("or_r2",  OP_OR,    16'h000F, 2'd2, 32'h0000_123F);

        // ACC wrap
        run_op("load_r0", OP_LOAD, 16'h0002, 2'd0, 32'h0000_0002);
        run_op("acc_1",   OP_ACC,  16'hFFFF, 2'd0, 32'h0001_0001);
        run_op("acc_2",   OP_ACC,  16'hFFFF, 2'd0, 32'h0001_0000);
        run_op("acc_r0",  OP_ADD,  16'h0000, 2'd0, 32'h0000_0000);
        step();

        // Backpressure: three ops, consumer stalled
        ready_out = 1'b0;
        drive(OP_ADD, 16'h0001, 2'd2);
        check("bp_rdy0", 64'(ready_ula), 64'd1);
        step();
        drive(OP_OR, 16'hF000, 2'd2);
        check("bp_rdy1", 64'(ready_ula), 64'd1);
        step();
        drive(OP_ADD, 16'h0002, 2'd1);
        check("bp_rdy_drop", 64'(ready_ula), 64'd0);
        check("bp_first_vld", 64'(valid_out), 64'd1);
        check("bp_first_data", 64'(data_out), 64'h0000_1235);
        for (int i = 0; i < 2; i++) begin
            step();
            $display("[TB] stall cycle %0d data=0x%h ready_ula=%0b", i, data_out, ready_ula);
            check("bp_stall_rdy", 64'(ready_ula), 64'd0);
            check("bp_stall_data", 64'(data_out), 64'h0000_1235);
        end
        ready_out = 1'b1;
        #1;
        check("bp_release_rdy", 64'(ready_ula), 64'd1);
        step();
        valid_ula = 1'b0;
        $display("[TB] release 2nd -> data=0x%h", data_out);
        check("bp_second_vld", 64'(valid_out), 64'd1);
        check("bp_second_data", 64'(data_out), 64'h0000_F234);
        step();
        $display("[TB] release 3rd -> data=0x%h", data_out);
        check("bp_third_vld", 64'(valid_out), 64'd1);
        check("bp_third_data", 64'(data_out), 64'h0001_0001);
        step();
        check("bp_drain", 64'(valid_out), 64'd0);

        // Reset mid-stream with two transactions in flight
        drive(OP_LOAD, 16'h5555, 2'd3);
        step();
        drive(OP_ADD, 16'h0001, 2'd3);
        step();
        valid_ula = 1'b0;
        check("mid_pre_vld", 64'(valid_out), 64'd1);
        check("mid_pre_data", 64'(data_out), 64'h0000_5555);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(valid_out), 64'd0);
        check("mid_rst_data", 64'(data_out), 64'd0);
        check("mid_rst_zero", 64'(zero_out), 64'd0);
        check("mid_rst_rdy", 64'(ready_ula), 64'd1);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mid_no_ghost", 64'(valid_out), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            run_op($sformatf("zeroed_r%0d", i), OP_ADD, 16'h0000, 2'(i), 32'h0000_0000);
        end
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
